// File: rtl/ysyx_22050039_idu_pipe.sv
// Decode stage: GPR file, busy scoreboard with write-back bypass, and a
// single-entry output register with valid/ready handshake on both sides.
module ysyx_22050039_idu_pipe #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32,
    parameter int unsigned NR_REG   = 32,
    parameter int unsigned REG_SEL  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_LEN-1:0] in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_src1,
    output logic [XLEN-1:0]     out_src2,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_SEL-1:0]  out_rd,
    output logic                out_rd_wen,
    output logic [2:0]          out_type,
    output logic [2:0]          out_funct3,
    output logic                out_funct7b5,
    input  logic                wb_en,
    input  logic [REG_SEL-1:0]  wb_rd,
    input  logic [XLEN-1:0]     wb_data
);

    localparam logic [2:0] TypeIll   = 3'd0;
    localparam logic [2:0] TypeOpImm = 3'd1;
    localparam logic [2:0] TypeOp    = 3'd2;
    localparam logic [2:0] TypeLui   = 3'd3;
    localparam logic [2:0] TypeAuipc = 3'd4;
    localparam logic [2:0] TypeJal   = 3'd5;

    logic [XLEN-1:0]    r_gpr [NR_REG];
    logic [NR_REG-1:0]  r_busy;
    logic [NR_REG-1:0]  w_busy_d;

    logic               r_out_valid;
    logic [XLEN-1:0]    r_src1, r_src2, r_imm, r_pc;
    logic [REG_SEL-1:0] r_rd;
    logic               r_rd_wen;
    logic [2:0]         r_type;
    logic [2:0]         r_funct3;
    logic               r_funct7b5;

    logic [6:0]         w_opcode;
    logic [REG_SEL-1:0] w_rd, w_rs1, w_rs2;
    logic [2:0]         w_type;
    logic               w_use1, w_use2, w_rd_wen;
    logic [31:0]        w_imm32;
    logic [XLEN-1:0]    w_imm, w_src1, w_src2;
    logic               w_wb_hit, w_byp1, w_byp2, w_byp_rd;
    logic               w_haz, w_accept;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];

    // Opcode decode: type, source usage and 32-bit immediate before sign extension
    always_comb begin
        w_type  = TypeIll;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_imm32 = '0;
        case (w_opcode)
            7'h13: begin
                w_type  = TypeOpImm;
                w_use1  = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'h33: begin
                w_type = TypeOp;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            7'h37: begin
                w_type  = TypeLui;
                w_imm32 = {in_inst[31:12], 12'b0};
            end
            7'h17: begin
                w_type  = TypeAuipc;
                w_imm32 = {in_inst[31:12], 12'b0};
            end
            7'h6F: begin
                w_type  = TypeJal;
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_imm    = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    assign w_rd_wen = (w_type != TypeIll) && (w_rd != '0);

    // A write-back this cycle feeds sources directly and retires the busy bit
    assign w_wb_hit = wb_en && (wb_rd != '0);
    assign w_byp1   = w_wb_hit && (wb_rd == w_rs1);
    assign w_byp2   = w_wb_hit && (wb_rd == w_rs2);
    assign w_byp_rd = w_wb_hit && (wb_rd == w_rd);

    assign w_src1 = !w_use1 ? '0 : (w_byp1 ? wb_data : r_gpr[w_rs1]);
    assign w_src2 = !w_use2 ? '0 : (w_byp2 ? wb_data : r_gpr[w_rs2]);

    assign w_haz = in_valid && ((w_use1 && r_busy[w_rs1] && !w_byp1) ||
                                (w_use2 && r_busy[w_rs2] && !w_byp2) ||
                                (w_rd_wen && r_busy[w_rd] && !w_byp_rd));

    assign in_ready = (!r_out_valid || out_ready) && !w_haz;
    assign w_accept = in_valid && in_ready;

    // Busy next state: set on accept wins over a same-cycle clear
    always_comb begin
        w_busy_d = r_busy;
        if (w_wb_hit) w_busy_d[wb_rd] = 1'b0;
        if (w_accept && w_rd_wen) w_busy_d[w_rd] = 1'b1;
    end

    // Busy scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_d;
    end

    // GPR file; x0 is only ever written by reset so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) r_gpr[i] <= '0;
        end else if (w_wb_hit) begin
            r_gpr[wb_rd] <= wb_data;
        end
    end

    // Output bundle register: load on accept, otherwise drop valid once consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_rd_wen    <= 1'b0;
            r_type      <= TypeIll;
            r_funct3    <= '0;
            r_funct7b5  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_imm       <= w_imm;
            r_pc        <= in_pc;
            r_rd        <= w_rd;
            r_rd_wen    <= w_rd_wen;
            r_type      <= w_type;
            r_funct3    <= in_inst[14:12];
            r_funct7b5  <= in_inst[30];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_src1     = r_src1;
    assign out_src2     = r_src2;
    assign out_imm      = r_imm;
    assign out_pc       = r_pc;
    assign out_rd       = r_rd;
    assign out_rd_wen   = r_rd_wen;
    assign out_type     = r_type;
    assign out_funct3   = r_funct3;
    assign out_funct7b5 = r_funct7b5;

endmodule
